// File: rtl/mips_pkg.sv
// Shared MIPS execute-stage constants: ALU op codes, opcode/funct encodings, forward selects.
package mips_pkg;

    localparam logic [3:0] ALU_SLL  = 4'd0;
    localparam logic [3:0] ALU_SRA  = 4'd1;
    localparam logic [3:0] ALU_SRL  = 4'd2;
    localparam logic [3:0] ALU_MUL  = 4'd3;
    localparam logic [3:0] ALU_DIV  = 4'd4;
    localparam logic [3:0] ALU_ADD  = 4'd5;
    localparam logic [3:0] ALU_SUB  = 4'd6;
    localparam logic [3:0] ALU_AND  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_XOR  = 4'd9;
    localparam logic [3:0] ALU_NOR  = 4'd10;
    localparam logic [3:0] ALU_SLT  = 4'd11;
    localparam logic [3:0] ALU_SLTU = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SRLV = 6'h06;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

endpackage

// File: rtl/alu_core.sv
// Combinational MIPS ALU: primary/secondary result, signed/unsigned overflow, equality.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
module alu_core
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [3:0]       aluop,
    output logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] r2,
    output logic             of,
    output logic             uof,
    output logic             eq
);

    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       diff;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     quot;
    logic [WIDTH-1:0]     rem;
    logic [4:0]           shamt;
    logic                 div_ovf;

    assign shamt = y[4:0];
    assign sum   = {1'b0, x} + {1'b0, y};
    assign diff  = {1'b0, x} - {1'b0, y};
    assign prod  = $signed({{WIDTH{x[WIDTH-1]}}, x}) * $signed({{WIDTH{y[WIDTH-1]}}, y});
    assign eq    = (x == y);

    // Most-negative / -1 has no representable quotient; pin it instead of relying on tool semantics.
    assign div_ovf = (x == {1'b1, {(WIDTH-1){1'b0}}}) && (y == {WIDTH{1'b1}});

    always_comb begin
        quot = '0;
        rem  = '0;
        if (y == '0) begin
            quot = {WIDTH{1'b1}};
            rem  = x;
        end else if (div_ovf) begin
            quot = x;
            rem  = '0;
        end else begin
            quot = $signed(x) / $signed(y);
            rem  = $signed(x) % $signed(y);
        end
    end

    always_comb begin
        r   = '0;
        r2  = '0;
        of  = 1'b0;
        uof = 1'b0;
        case (aluop)
            ALU_SLL:  r = x << shamt;
            ALU_SRA:  r = $signed(x) >>> shamt;
            ALU_SRL:  r = x >> shamt;
            ALU_MUL: begin
                r  = prod[WIDTH-1:0];
                r2 = prod[2*WIDTH-1:WIDTH];
            end
            ALU_DIV: begin
                r  = quot;
                r2 = rem;
            end
            ALU_ADD: begin
                r   = sum[WIDTH-1:0];
                of  = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
                uof = sum[WIDTH];
            end
            ALU_SUB: begin
                r   = diff[WIDTH-1:0];
                of  = (x[WIDTH-1] != y[WIDTH-1]) && (diff[WIDTH-1] != x[WIDTH-1]);
                uof = diff[WIDTH];
            end
            ALU_AND:  r = x & y;
            ALU_OR:   r = x | y;
            ALU_XOR:  r = x ^ y;
            ALU_NOR:  r = ~(x | y);
            ALU_SLT:  r = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
            ALU_SLTU: r = {{(WIDTH-1){1'b0}}, (x < y)};
            default:  r = '0;
        endcase
    end

endmodule

// File: rtl/exec_alu_stage.sv
// MIPS execute stage: operand forwarding/selection, ALU, EX/MEM result registers.
// Latency: 1 cycle to registered outputs; eq_comb is same-cycle.
// Backpressure: en=0 holds all registers (stall); rst overrides en.
module exec_alu_stage
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic [3:0]       aluop,
    input  logic [WIDTH-1:0] rfd1,
    input  logic [WIDTH-1:0] rfd2,
    input  logic [WIDTH-1:0] immext,
    input  logic [1:0]       fwd_rs,
    input  logic [1:0]       fwd_rt,
    input  logic [WIDTH-1:0] mem_fwd,
    input  logic [WIDTH-1:0] wb_fwd,
    output logic [WIDTH-1:0] alu_r,
    output logic [WIDTH-1:0] alu_r2,
    output logic             alu_of,
    output logic             alu_uof,
    output logic             alu_eq,
    output logic [WIDTH-1:0] store_data,
    output logic             eq_comb
);

    logic [WIDTH-1:0] rs_val, rt_val, x, y;
    logic             is_rtype, shift, src_b_imm;
    logic [WIDTH-1:0] r_d, r2_d;
    logic             of_d, uof_d, eq_d;
    logic [WIDTH-1:0] r_q, r2_q, sd_q;
    logic             of_q, uof_q, eq_q;

    always_comb begin
        rs_val = rfd1;
        case (fwd_rs)
            FWD_MEM: rs_val = mem_fwd;
            FWD_WB:  rs_val = wb_fwd;
            default: rs_val = rfd1;
        endcase
        rt_val = rfd2;
        case (fwd_rt)
            FWD_MEM: rt_val = mem_fwd;
            FWD_WB:  rt_val = wb_fwd;
            default: rt_val = rfd2;
        endcase
    end

    assign is_rtype = (op == OP_RTYPE);
    assign shift    = is_rtype && (funct == FN_SLL || funct == FN_SRL ||
                                   funct == FN_SRA || funct == FN_SRLV);

    always_comb begin
        src_b_imm = 1'b0;
        case (op)
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI,
            OP_LW, OP_LBU, OP_SW: src_b_imm = 1'b1;
            OP_RTYPE: src_b_imm = (funct == FN_SLL || funct == FN_SRL || funct == FN_SRA);
            default:  src_b_imm = 1'b0;
        endcase
    end

    // Shifts put the shifted value (rt) on X; variable shifts take the amount from rs.
    assign x = shift ? rt_val : rs_val;

    always_comb begin
        y = rt_val;
        if (src_b_imm)
            y = immext;
        else if (is_rtype && funct == FN_SRLV)
            y = rs_val;
    end

    alu_core #(.WIDTH(WIDTH)) u_alu (
        .x     (x),
        .y     (y),
        .aluop (aluop),
        .r     (r_d),
        .r2    (r2_d),
        .of    (of_d),
        .uof   (uof_d),
        .eq    (eq_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q   <= '0;
            r2_q  <= '0;
            of_q  <= 1'b0;
            uof_q <= 1'b0;
            eq_q  <= 1'b0;
            sd_q  <= '0;
        end else if (en) begin
            r_q   <= r_d;
            r2_q  <= r2_d;
            of_q  <= of_d;
            uof_q <= uof_d;
            eq_q  <= eq_d;
            sd_q  <= rt_val;
        end
    end

    assign alu_r      = r_q;
    assign alu_r2     = r2_q;
    assign alu_of     = of_q;
    assign alu_uof    = uof_q;
    assign alu_eq     = eq_q;
    assign store_data = sd_q;
    assign eq_comb    = eq_d;

endmodule

// File: tb/tb_exec_alu_stage.sv
// Directed-vector bench for exec_alu_stage; expected values are hand-computed constants.
module tb_exec_alu_stage;

    logic        clk = 1'b0;
    logic        rst, en;
    logic [5:0]  op, funct;
    logic [3:0]  aluop;
    logic [31:0] rfd1, rfd2, immext, mem_fwd, wb_fwd;
    logic [1:0]  fwd_rs, fwd_rt;
    logic [31:0] alu_r, alu_r2, store_data;
    logic        alu_of, alu_uof, alu_eq, eq_comb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exec_alu_stage #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .op         (op),
        .funct      (funct),
        .aluop      (aluop),
        .rfd1       (rfd1),
        .rfd2       (rfd2),
        .immext     (immext),
        .fwd_rs     (fwd_rs),
        .fwd_rt     (fwd_rt),
        .mem_fwd    (mem_fwd),
        .wb_fwd     (wb_fwd),
        .alu_r      (alu_r),
        .alu_r2     (alu_r2),
        .alu_of     (alu_of),
        .alu_uof    (alu_uof),
        .alu_eq     (alu_eq),
        .store_data (store_data),
        .eq_comb    (eq_comb)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] o, input logic [5:0] f, input logic [3:0] a,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] im);
        op = o; funct = f; aluop = a; rfd1 = d1; rfd2 = d2; immext = im;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0;
        fwd_rs = 2'b00; fwd_rt = 2'b00; mem_fwd = '0; wb_fwd = '0;
        drive(6'h00, 6'h20, 4'd5, 32'h1234_5678, 32'h1234_5678, 32'h0);
        tick();
        check("rst_r",   alu_r, 32'h0);
        check("rst_r2",  alu_r2, 32'h0);
        check("rst_of",  {31'b0, alu_of}, 32'h0);
        check("rst_uof", {31'b0, alu_uof}, 32'h0);
        check("rst_eq",  {31'b0, alu_eq}, 32'h0);
        check("rst_sd",  store_data, 32'h0);
        rst = 1'b0; en = 1'b1;

        drive(6'h00, 6'h20, 4'd5, 32'h7FFF_FFFF, 32'h1, 32'h0);
        tick();
        check("add_of_r",   alu_r, 32'h8000_0000);
        check("add_of_of",  {31'b0, alu_of}, 32'h1);
        check("add_of_uof", {31'b0, alu_uof}, 32'h0);
        check("add_of_r2",  alu_r2, 32'h0);
        check("add_of_sd",  store_data, 32'h1);

        drive(6'h00, 6'h06, 4'd6, 32'h8000_0000, 32'h1, 32'h0);
        drive(6'h00, 6'h22, 4'd6, 32'h8000_0000, 32'h1, 32'h0);
        tick();
        check("sub_of_r",   alu_r, 32'h7FFF_FFFF);
        check("sub_of_of",  {31'b0, alu_of}, 32'h1);
        check("sub_of_uof", {31'b0, alu_uof}, 32'h0);

        drive(6'h00, 6'h00, 4'd0, 32'h0, 32'h3, 32'h4);
        tick();
        check("sll_imm", alu_r, 32'h30);
        drive(6'h00, 6'h06, 4'd0, 32'h4, 32'h3, 32'h1F);
        tick();
        check("sll_var", alu_r, 32'h30);
        drive(6'h00, 6'h03, 4'd1, 32'h0, 32'h8000_0000, 32'h4);
        tick();
        check("sra", alu_r, 32'hF800_0000);
        drive(6'h00, 6'h02, 4'd2, 32'h0, 32'h8000_0000, 32'h4);
        tick();
        check("srl", alu_r, 32'h0800_0000);

        fwd_rs = 2'b01; mem_fwd = 32'd10; wb_fwd = 32'd20;
        drive(6'h08, 6'h00, 4'd5, 32'd99, 32'd0, 32'hFFFF_FFFF);
        tick();
        check("addi_mem",     alu_r, 32'd9);
        check("addi_mem_uof", {31'b0, alu_uof}, 32'h1);
        check("addi_mem_of",  {31'b0, alu_of}, 32'h0);
        fwd_rs = 2'b10;
        tick();
        check("addi_wb", alu_r, 32'd19);
        fwd_rs = 2'b11; rfd1 = 32'd5; immext = 32'd1;
        tick();
        check("fwd11_reg", alu_r, 32'd6);
        fwd_rs = 2'b00;

        drive(6'h00, 6'h18, 4'd3, 32'hFFFF_FFFE, 32'h3, 32'h0);
        tick();
        check("mul_lo", alu_r, 32'hFFFF_FFFA);
        check("mul_hi", alu_r2, 32'hFFFF_FFFF);
        drive(6'h00, 6'h1A, 4'd4, 32'd7, 32'd2, 32'h0);
        tick();
        check("div_q", alu_r, 32'd3);
        check("div_r", alu_r2, 32'd1);
        drive(6'h00, 6'h1A, 4'd4, 32'hFFFF_FFF9, 32'd2, 32'h0);
        tick();
        check("divneg_q", alu_r, 32'hFFFF_FFFD);
        check("divneg_r", alu_r2, 32'hFFFF_FFFF);
        drive(6'h00, 6'h1A, 4'd4, 32'd7, 32'd0, 32'h0);
        tick();
        check("div0_q", alu_r, 32'hFFFF_FFFF);
        check("div0_r", alu_r2, 32'd7);

        drive(6'h00, 6'h2A, 4'd11, 32'hFFFF_FFFF, 32'h1, 32'h0);
        tick();
        check("slt", alu_r, 32'd1);
        aluop = 4'd12;
        tick();
        check("sltu",    alu_r, 32'd0);
        check("sltu_r2", alu_r2, 32'd0);
        drive(6'h00, 6'h27, 4'd10, 32'h0, 32'h0, 32'h0);
        tick();
        check("nor", alu_r, 32'hFFFF_FFFF);
        aluop = 4'd13;
        tick();
        check("op13", alu_r, 32'h0);

        drive(6'h04, 6'h00, 4'd6, 32'd5, 32'd5, 32'h0000_0100);
        #1;
        check("beq_eqc_1", {31'b0, eq_comb}, 32'h1);
        tick();
        check("beq_eq_reg", {31'b0, alu_eq}, 32'h1);
        check("beq_sub_r",  alu_r, 32'h0);
        rfd2 = 32'd6;
        #1;
        check("beq_eqc_0", {31'b0, eq_comb}, 32'h0);

        drive(6'h00, 6'h26, 4'd9, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0);
        tick();
        check("xor", alu_r, 32'h0000_FF00);
        en = 1'b0;
        drive(6'h00, 6'h20, 4'd5, 32'h7FFF_FFFF, 32'h1, 32'h0);
        tick();
        tick();
        check("stall_r",  alu_r, 32'h0000_FF00);
        check("stall_of", {31'b0, alu_of}, 32'h0);
        check("stall_sd", store_data, 32'h0000_0FF0);
        en = 1'b1; rst = 1'b1;
        tick();
        check("rst2_r",  alu_r, 32'h0);
        check("rst2_of", {31'b0, alu_of}, 32'h0);
        check("rst2_sd", store_data, 32'h0);
        rst = 1'b0;

        fwd_rt = 2'b10; wb_fwd = 32'h0000_ABCD;
        drive(6'h2B, 6'h00, 4'd5, 32'h100, 32'h5555_5555, 32'h8);
        tick();
        check("sw_addr", alu_r, 32'h108);
        check("sw_data", store_data, 32'h0000_ABCD);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exec_alu_stage.md
Name: exec_alu_stage

Overview:
- Execute-stage datapath slice of the 5-stage MIPS pipeline.
- Resolves forwarded register operands and selects ALU operand A/B from opcode/funct (immediate vs. register, shift-operand swap).
- Performs the 4-bit-coded ALU operation and registers the results into the EX/MEM boundary.
- Consumed by the data-memory stage and the branch/next-PC logic.

Parameters:
- WIDTH, 32, datapath width; all arithmetic rules below assume 32.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  register enable; 0 = hold (pipeline stall).
- op  in  6  EX instruction opcode.
- funct  in  6  EX instruction funct field.
- aluop  in  4  ALU operation code.
- rfd1  in  WIDTH  rs value read in ID.
- rfd2  in  WIDTH  rt value read in ID.
- immext  in  WIDTH  extended immediate/shamt.
- fwd_rs  in  2  rs forward select.
- fwd_rt  in  2  rt forward select.
- mem_fwd  in  WIDTH  EX/MEM ALU result.
- wb_fwd  in  WIDTH  WB write-back data.
- alu_r  out  WIDTH  registered primary result.
- alu_r2  out  WIDTH  registered secondary result (mul high / div remainder).
- alu_of  out  1  registered signed overflow.
- alu_uof  out  1  registered unsigned overflow.
- alu_eq  out  1  registered X==Y.
- store_data  out  WIDTH  registered forwarded rt value for stores.
- eq_comb  out  1  combinational X==Y, for same-cycle branch resolution.

Behaviour:
- Forwarding applies to rs_val and rt_val independently, using fwd_rs / fwd_rt:
  - 00: register value (rfd1 / rfd2).
  - 01: mem_fwd.
  - 10: wb_fwd.
  - 11: treated as 00.
- Shift detection: shift = (op==0) && funct in {0x00 sll, 0x02 srl, 0x03 sra, 0x06 srlv}.
- Operand A (X) = rt_val if shift, else rs_val.
- src_b_imm = 1 when either:
  - op in {0x08, 0x09, 0x0A, 0x0B, 0x0C, 0x0D, 0x23, 0x24, 0x2B}, or
  - op==0 && funct in {0x00, 0x02, 0x03}.
  - Otherwise 0; branches 0x04/0x05 and all other R-types use a register.
- Operand B (Y):
  - immext if src_b_imm.
  - rs_val if op==0 && funct==0x06.
  - rt_val otherwise.
- ALU operations (Y[4:0] is the shift amount):
  - 0 SLL: X << Y.
  - 1 SRA: X >>> Y, arithmetic.
  - 2 SRL: X >> Y, logical.
  - 3 MUL: signed 64-bit product; R = low word, R2 = high word.
  - 4 DIV: signed; R = quotient, R2 = remainder (sign of X). Y==0 → R = 0xFFFFFFFF, R2 = X.
  - 5 ADD: X+Y.
  - 6 SUB: X-Y.
  - 7 AND.
  - 8 OR.
  - 9 XOR.
  - 10 NOR.
  - 11 SLT: R = signed X<Y (0/1).
  - 12 SLTU: R = unsigned X<Y (0/1).
  - 13–15: R = 0.
  - For every op other than MUL and DIV, R2 = 0.
- Flags:
  - OF: set only for ADD (operands same sign, result sign differs) and SUB (operands differ in sign, result sign ≠ X sign); else 0.
  - UOF: ADD carry-out, or SUB borrow (X<Y unsigned); else 0.
  - Equal: X==Y for all ops.
- Registers:
  - Cover alu_r, alu_r2, alu_of, alu_uof, alu_eq, store_data.
  - rst=1 → all cleared to 0 on next edge; rst takes priority over en.
  - en=1 → capture the combinational values; en=0 → hold.
  - Latency: 1 cycle from inputs to registered outputs.
- store_data captures the forwarded rt_val, not operand B.
- eq_comb is purely combinational, with no reset dependence.

Decomposition:
- Shared package `mips_pkg`:
  - ALU op constants ALU_SLL … ALU_SLTU.
  - Opcode/funct constants.
  - Forward-select constants FWD_REG / FWD_MEM / FWD_WB.
- One natural sub-module `alu_core`: combinational X, Y, aluop → R, R2, OF, UOF, Equal.
- Operand selection and registers stay in the top.

Test Plan:
- add overflow: op=0, funct=0x20, aluop=5, rfd1=0x7FFFFFFF, rfd2=1, fwd=00, en=1 → after 1 clk alu_r=0x80000000, alu_of=1, alu_uof=0.
- sll via imm: op=0, funct=0x00, aluop=0, rfd2=0x00000003, immext=4 → alu_r=0x30. Repeat with funct=0x06, rfd1=4 → alu_r=0x30.
- forwarding + addi:
  - op=0x08, aluop=5, fwd_rs=01, mem_fwd=10, immext=0xFFFFFFFF → alu_r=9.
  - With fwd_rs=10, wb_fwd=20 → alu_r=19.
- mul/div:
  - aluop=3, X=0xFFFFFFFE, Y=3 → R=0xFFFFFFFA, R2=0xFFFFFFFF.
  - aluop=4, X=7, Y=2 → R=3, R2=1.
  - Y=0 → R=0xFFFFFFFF, R2=7.
- slt/sltu with X=0xFFFFFFFF, Y=1 → aluop 11 R=1; aluop 12 R=0. beq op=0x04 with rfd1=rfd2=5 → eq_comb=1 same cycle.
- stall/reset:
  - Load values, then en=0 with changed inputs → outputs hold.
  - rst=1 with en=1 → all outputs 0 next edge.
  - sw op=0x2B with fwd_rt=10, wb_fwd=0xABCD → store_data=0xABCD.
